imem_portb_arbiter: RTL and testbench
=====================================

// Module: imem_portb_arbiter
// PURPOSE
//  Shares IMEM port B (sync-read, byte-strobed) between the UART bootloader write
//  stream and the LSU read-only IMEM window. Replaces the static boot-wins mux.
//  Enforces fairness so a long boot download cannot starve LSU reads, tracks the
//  1-cycle read latency back to the LSU, and flags boot activity so the SoC can hold the core.
// PARAMETERS
//  ADDR_WIDTH      11  IMEM word-address width
//  DATA_WIDTH      32  IMEM data width (multiple of 8)
//  MAX_BOOT_BURST  16  max consecutive boot grants while lsu_req waits (>=1)
//  BOOT_IDLE_CYC   64  boot_req-low cycles before boot_active drops (>=1)
// PORTS
//  clk          in   1               system clock
//  nrst         in   1               async active-low reset
//  boot_req     in   1               bootloader write request
//  boot_addr    in   ADDR_WIDTH      boot write word address
//  boot_wdata   in   DATA_WIDTH      boot write data
//  boot_gnt     out  1               boot write accepted this cycle
//  lsu_req      in   1               LSU read request
//  lsu_addr     in   ADDR_WIDTH      LSU read word address
//  lsu_gnt      out  1               LSU read issued this cycle
//  lsu_rvalid   out  1               lsu_rdata valid (1 cycle after lsu_gnt)
//  lsu_rdata    out  DATA_WIDTH      read data
//  boot_active  out  1               boot download in progress (core hold)
//  mem_en       out  1               port B enable
//  mem_we       out  1               port B write enable
//  mem_wstrb    out  DATA_WIDTH/8    port B byte strobes
//  mem_addr     out  ADDR_WIDTH      port B address
//  mem_din      out  DATA_WIDTH      port B write data
//  mem_dout     in   DATA_WIDTH      port B read data (registered inside IMEM)
// BEHAVIOUR
//  - Reset (async): all outputs 0; burst_cnt=0, idle_cnt=0, rvalid_q=0.
//  - Request rule: req, addr, wdata held stable until the cycle its gnt=1. Gnt is
//    combinational from req + registered state. At most one gnt per cycle.
//  - Arbitration, one access per cycle:
//    only boot_req -> boot_gnt; only lsu_req -> lsu_gnt;
//    both -> boot_gnt unless burst_cnt==MAX_BOOT_BURST, then lsu_gnt.
//  - burst_cnt: +1 on boot_gnt while lsu_req=1 (saturating at MAX_BOOT_BURST);
//    cleared on lsu_gnt or whenever lsu_req=0.
//  - Mem drive: mem_en=boot_gnt|lsu_gnt. On boot_gnt: mem_we=1, mem_wstrb=all ones,
//    addr/din from boot. On lsu_gnt: mem_we=0, mem_wstrb=0, addr=lsu_addr, din=0.
//    Idle: mem_en=0, mem_we=0, mem_wstrb=0, addr=0, din=0.
//  - Read return: rvalid_q <= lsu_gnt. lsu_rvalid=rvalid_q. lsu_rdata=mem_dout
//    when rvalid_q, else 0. Back-to-back LSU grants give back-to-back rvalid.
//  - Write-then-read same address next cycle returns the new data. Port B write
//    precedes any later read.
//  - boot_active FSM with states IDLE and ACTIVE:
//    IDLE->ACTIVE on boot_gnt. In ACTIVE, idle_cnt clears when boot_req=1 and
//    increments when boot_req=0. ACTIVE->IDLE when idle_cnt reaches BOOT_IDLE_CYC-1
//    while boot_req=0. boot_active is registered: 1 in ACTIVE.
//  - Reset mid-operation: an in-flight read is dropped (no rvalid after reset). A boot
//    write granted in the same cycle as reset assertion is not guaranteed.
// TESTING
//  1 Boot only: 3 writes to 0x000..0x002 (0xA5A5_0000+i) -> boot_gnt each cycle,
//    mem_we=1, mem_wstrb=4'hF; boot_active=1 after first grant.
//  2 LSU only: read addr 0x001 -> lsu_gnt in cycle 0; lsu_rvalid=1 and
//    lsu_rdata=0xA5A5_0001 in cycle 1; mem_we=0 throughout.
//  3 Contention: boot_req and lsu_req held for 40 cycles, MAX_BOOT_BURST=16 ->
//    16 boot grants, then 1 LSU grant, then 16 boot grants, repeating;
//    never two grants in one cycle.
//  4 Idle timeout: BOOT_IDLE_CYC=4 and boot_req dropped after one write ->
//    boot_active falls exactly 4 cycles after boot_req=0. A new boot_req at
//    idle cycle 2 keeps boot_active high.
//  5 Write-then-read: boot writes 0xDEAD_BEEF to 0x7FF, LSU reads 0x7FF next
//    cycle -> lsu_rdata=0xDEAD_BEEF.
//  6 Reset mid-read: nrst low in the cycle after lsu_gnt -> lsu_rvalid=0 and
//    boot_active=0 immediately; no stale rvalid after nrst rises.

Source files
------------

// File: rtl/imem_portb_arbiter.sv
// imem_portb_arbiter
// Shares IMEM port B between the UART boot write stream and the LSU read window.
// Boot writes win by default. A waiting LSU read is served after at most
// MAX_BOOT_BURST consecutive boot grants. The 1-cycle read latency is tracked
// back to the LSU. boot_active tells the SoC to hold the core while a download runs.
module imem_portb_arbiter #(
    parameter int ADDR_WIDTH     = 11,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_BOOT_BURST = 16,
    parameter int BOOT_IDLE_CYC  = 64
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    boot_req,
    input  logic [ADDR_WIDTH-1:0]   boot_addr,
    input  logic [DATA_WIDTH-1:0]   boot_wdata,
    output logic                    boot_gnt,
    input  logic                    lsu_req,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr,
    output logic                    lsu_gnt,
    output logic                    lsu_rvalid,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,
    output logic                    boot_active,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_din,
    input  logic [DATA_WIDTH-1:0]   mem_dout
);

    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int BURST_W = $clog2(MAX_BOOT_BURST + 1);
    localparam int IDLE_W  = (BOOT_IDLE_CYC > 1) ? $clog2(BOOT_IDLE_CYC) : 1;

    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BOOT_BURST);
    localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(BOOT_IDLE_CYC - 1);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACTIVE = 1'b1;

    logic               boot_gnt_s;
    logic               lsu_gnt_s;
    logic               burst_lock_s;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [IDLE_W-1:0]  idle_q,  idle_d;
    logic               state_q, state_d;
    logic               rvalid_q;

    // Grant selection: boot wins unless a waiting LSU read has hit the burst limit.
    always_comb begin
        boot_gnt_s   = 1'b0;
        lsu_gnt_s    = 1'b0;
        burst_lock_s = lsu_req && (burst_q == BURST_MAX);
        if (boot_req && !burst_lock_s) begin
            boot_gnt_s = 1'b1;
        end else if (lsu_req) begin
            lsu_gnt_s = 1'b1;
        end else begin
            boot_gnt_s = 1'b0;
            lsu_gnt_s  = 1'b0;
        end
    end

    assign boot_gnt = boot_gnt_s;
    assign lsu_gnt  = lsu_gnt_s;

    // Port B drive: the granted requester owns the port, otherwise all-zero.
    always_comb begin
        mem_en    = boot_gnt_s | lsu_gnt_s;
        mem_we    = 1'b0;
        mem_wstrb = {STRB_W{1'b0}};
        mem_addr  = {ADDR_WIDTH{1'b0}};
        mem_din   = {DATA_WIDTH{1'b0}};
        if (boot_gnt_s) begin
            mem_we    = 1'b1;
            mem_wstrb = {STRB_W{1'b1}};
            mem_addr  = boot_addr;
            mem_din   = boot_wdata;
        end else if (lsu_gnt_s) begin
            mem_addr  = lsu_addr;
        end else begin
            mem_we    = 1'b0;
        end
    end

    // Burst counter: counts boot grants that made a waiting LSU read wait.
    always_comb begin
        burst_d = burst_q;
        if (!lsu_req || lsu_gnt_s) begin
            burst_d = {BURST_W{1'b0}};
        end else if (boot_gnt_s && (burst_q != BURST_MAX)) begin
            burst_d = burst_q + {{(BURST_W-1){1'b0}}, 1'b1};
        end else begin
            burst_d = burst_q;
        end
    end

    // Boot activity FSM: enter on a boot grant, leave after a run of quiet cycles.
    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        case (state_q)
            ST_IDLE: begin
                idle_d = {IDLE_W{1'b0}};
                if (boot_gnt_s) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (boot_req) begin
                    idle_d = {IDLE_W{1'b0}};
                end else if (idle_q == IDLE_LAST) begin
                    idle_d  = {IDLE_W{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    idle_d = idle_q + {{(IDLE_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                idle_d  = {IDLE_W{1'b0}};
            end
        endcase
    end

    // State registers; an in-flight read is dropped by reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            burst_q  <= {BURST_W{1'b0}};
            idle_q   <= {IDLE_W{1'b0}};
            state_q  <= ST_IDLE;
            rvalid_q <= 1'b0;
        end else begin
            burst_q  <= burst_d;
            idle_q   <= idle_d;
            state_q  <= state_d;
            rvalid_q <= lsu_gnt_s;
        end
    end

    assign boot_active = (state_q == ST_ACTIVE);
    assign lsu_rvalid  = rvalid_q;
    assign lsu_rdata   = rvalid_q ? mem_dout : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_imem_portb_arbiter.sv
// Self-checking bench for imem_portb_arbiter: directed scenarios followed by
// random traffic, all compared against a behavioural reference model.
module tb_imem_portb_arbiter;

    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int BURST = 16;
    localparam int IDLEC = 4;

    logic          clk = 1'b0;
    logic          nrst;
    logic          boot_req;
    logic [AW-1:0] boot_addr;
    logic [DW-1:0] boot_wdata;
    logic          boot_gnt;
    logic          lsu_req;
    logic [AW-1:0] lsu_addr;
    logic          lsu_gnt;
    logic          lsu_rvalid;
    logic [DW-1:0] lsu_rdata;
    logic          boot_active;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_wstrb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    imem_portb_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .MAX_BOOT_BURST(BURST), .BOOT_IDLE_CYC(IDLEC)
    ) dut (
        .clk(clk), .nrst(nrst),
        .boot_req(boot_req), .boot_addr(boot_addr), .boot_wdata(boot_wdata), .boot_gnt(boot_gnt),
        .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_gnt(lsu_gnt),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .boot_active(boot_active),
        .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Behavioural IMEM port B: byte-strobed write, registered read.
    logic [DW-1:0] imem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) imem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
            end else begin
                mem_dout <= imem[mem_addr];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            streak;       // boot grants taken while the LSU was kept waiting
    bit            m_active;
    int            m_quiet;      // consecutive boot_req-low cycles while active
    bit            m_rvalid;
    logic [DW-1:0] m_rdata;
    bit            last_bg, last_lg;
    int            n_bg, n_lg;

    task automatic model_reset();
        streak = 0; m_active = 0; m_quiet = 0; m_rvalid = 0; m_rdata = '0;
        last_bg = 0; last_lg = 0;
    endtask

    // One clock cycle: check mid-cycle, then advance the model across the edge.
    task automatic step();
        bit            e_bg, e_lg;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        #4;
        e_bg   = boot_req && !(lsu_req && streak >= BURST);
        e_lg   = lsu_req && !e_bg;
        e_addr = e_bg ? boot_addr : (e_lg ? lsu_addr : '0);
        e_din  = e_bg ? boot_wdata : '0;
        chk("boot_gnt", boot_gnt, e_bg);
        chk("lsu_gnt", lsu_gnt, e_lg);
        chk("mem_en", mem_en, e_bg | e_lg);
        chk("mem_we", mem_we, e_bg);
        chk("mem_wstrb", mem_wstrb, e_bg ? 4'hF : 4'h0);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_din", mem_din, e_din);
        chk("lsu_rvalid", lsu_rvalid, m_rvalid);
        chk("lsu_rdata", lsu_rdata, m_rdata);
        chk("boot_active", boot_active, m_active);
        @(posedge clk);
        if (e_bg) n_bg++;
        if (e_lg) n_lg++;
        if (!lsu_req || e_lg) streak = 0;
        else if (e_bg) streak = streak + 1;
        m_rvalid = e_lg;
        m_rdata  = e_lg ? ref_mem[lsu_addr] : '0;
        if (e_bg) ref_mem[boot_addr] = boot_wdata;
        if (!m_active) begin
            if (e_bg) begin m_active = 1; m_quiet = 0; end
        end else if (boot_req) begin
            m_quiet = 0;
        end else begin
            m_quiet++;
            if (m_quiet >= IDLEC) m_active = 0;
        end
        last_bg = e_bg;
        last_lg = e_lg;
        #1;
    endtask

    task automatic idle_inputs();
        boot_req = 0; boot_addr = '0; boot_wdata = '0; lsu_req = 0; lsu_addr = '0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            imem[i] = '0;
            ref_mem[i] = '0;
        end
        mem_dout = '0;
        n_bg = 0; n_lg = 0;
        model_reset();
        idle_inputs();
        nrst = 0;
        #1;
        chk("rst_boot_active", boot_active, 1'b0);
        chk("rst_rvalid", lsu_rvalid, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        repeat (2) @(posedge clk);
        #1 nrst = 1;
        step();

        // 1: boot-only writes
        for (int i = 0; i < 3; i++) begin
            boot_req = 1; boot_addr = AW'(i); boot_wdata = 32'hA5A5_0000 + 32'(i);
            step();
            chk("t1_boot_active", boot_active, 1'b1);
        end
        idle_inputs();

        // 2: LSU-only read of address 1
        lsu_req = 1; lsu_addr = 11'h001;
        step();
        lsu_req = 0;
        chk("t2_rvalid", lsu_rvalid, 1'b1);
        chk("t2_rdata", lsu_rdata, 32'hA5A5_0001);
        step();
        chk("t2_rvalid_drop", lsu_rvalid, 1'b0);
        repeat (6) step();

        // 3: contention for 40 cycles
        n_bg = 0; n_lg = 0;
        boot_req = 1; lsu_req = 1;
        for (int c = 0; c < 40; c++) begin
            boot_addr = AW'(100 + c); boot_wdata = 32'h3000_0000 + 32'(c);
            lsu_addr = AW'(c);
            step();
            chk("t3_lsu_slot", last_lg, (c == 16 || c == 33));
        end
        chk("t3_boot_count", n_bg, 38);
        chk("t3_lsu_count", n_lg, 2);
        idle_inputs();
        repeat (6) step();
        chk("t3_active_off", boot_active, 1'b0);

        // 4: idle timeout, then a re-request at quiet cycle 2
        boot_req = 1; boot_addr = 11'h010; boot_wdata = 32'h0000_1111;
        step();
        idle_inputs();
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t4_timeout", boot_active, (k < 4));
        end
        boot_req = 1; boot_addr = 11'h011; boot_wdata = 32'h0000_2222;
        step();
        idle_inputs();
        repeat (2) step();
        boot_req = 1; boot_addr = 11'h012; boot_wdata = 32'h0000_3333;
        step();
        idle_inputs();
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("t4_kept", boot_active, 1'b1);
        end

        // 5: write then read the same address next cycle
        boot_req = 1; boot_addr = 11'h7FF; boot_wdata = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        lsu_req = 1; lsu_addr = 11'h7FF;
        step();
        lsu_req = 0;
        chk("t5_rdata", lsu_rdata, 32'hDEAD_BEEF);

        // 6: reset while a read is returning
        lsu_req = 1; lsu_addr = 11'h7FF;
        step();
        idle_inputs();
        chk("t6_rvalid_pre", lsu_rvalid, 1'b1);
        nrst = 0;
        #1;
        chk("t6_rvalid_rst", lsu_rvalid, 1'b0);
        chk("t6_active_rst", boot_active, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 nrst = 1;
        repeat (3) begin
            step();
            chk("t6_no_stale", lsu_rvalid, 1'b0);
        end

        // Random traffic; a request is held unchanged until it is granted.
        for (int n = 0; n < 2000; n++) begin
            if (!boot_req || last_bg) begin
                boot_req   = ($urandom_range(0, 99) < 60);
                boot_addr  = AW'($urandom_range(0, 15));
                boot_wdata = $urandom;
            end
            if (!lsu_req || last_lg) begin
                lsu_req  = ($urandom_range(0, 99) < 50);
                lsu_addr = AW'($urandom_range(0, 15));
            end
            step();
        end
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
